branch_resolve_ras: RTL and testbench
=====================================

# branch_resolve_ras

Parametrised branch-resolution stage for the KGP-RISC execute path. It evaluates conditional and unconditional branches from the ALU flags, computes the next PC, and handles call and return through an internal return-address stack (RAS) of configurable depth. Results are registered and appear one cycle after the request. Fetch uses exNPC/PCSrc to redirect; writeback uses ra for the link register.

## Interface
- PC_W, 10: program-counter width.
- LABEL_W, 25: branch label field width.
- XLEN, 32: register/link width.
- RAS_DEPTH, 8: return-address stack entries; power of two, ≥2.
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- flush  in  1: squash; drops the current request and empties the RAS.
- in_valid  in  1: request qualifier.
- opcode  in  3: instruction class; branch class is 3'b011.
- fcode  in  4: branch function code.
- label  in  LABEL_W: absolute target.
- carryFlag, zFlag, overflowFlag, signFlag  in  1 each: ALU flags.
- PC  in  PC_W: address of this instruction.
- rs_val  in  XLEN: register operand used by br and by the ret fallback.
- out_valid  out  1: results valid.
- exNPC  out  PC_W: next PC.
- PCSrc  out  1: 1 = redirect fetch to exNPC.
- ra  out  XLEN: link value; nonzero only for bl.
- ras_overflow  out  1: one-cycle pulse when a push overwrites the oldest entry.
- ras_underflow  out  1: one-cycle pulse when a ret finds the RAS empty.

## Operation
- fcode encoding, branch class only:
  - 0000 b: always taken.
  - 0001 bz: taken if z. 0010 bnz: taken if !z.
  - 0011 bcy: taken if c. 0100 bncy: taken if !c.
  - 0101 bv: taken if v. 0110 bnv: taken if !v.
  - 0111 bltz: taken if s.
  - 1000 bl: call.
  - 1001 br: jump to rs_val[PC_W-1:0].
  - 1010 ret: return.
  - 1011–1111: reserved, not taken.
- seq = PC+1, modulo 2^PC_W; wrap from all-ones to 0 is legal.
- Taken branch: PCSrc=1, exNPC = label[PC_W-1:0]; upper label bits are ignored.
- Not taken or reserved fcode: PCSrc=0, exNPC=seq.
- Non-branch opcode with in_valid=1: out_valid=1, PCSrc=0, exNPC=seq, ra=0, RAS untouched.
- bl:
  - PCSrc=1, exNPC=label[PC_W-1:0], ra = zero-extended seq.
  - Pushes seq onto the RAS.
- ret:
  - RAS non-empty: pops, PCSrc=1, exNPC = popped value.
  - RAS empty: PCSrc=1, exNPC=rs_val[PC_W-1:0], ras_underflow pulses, count stays 0.
- RAS is a circular buffer with a top pointer (log2 RAS_DEPTH bits) and a count (0..RAS_DEPTH).
  - Push when full: top advances and wraps, the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow pulses.
  - Pop: reads entry[top], top decrements mod RAS_DEPTH, count decrements.
- in_valid=0: out_valid=0. All other outputs hold their previous values, except the pulses, which deassert.
- flush has priority over in_valid in the same cycle:
  - next cycle out_valid=0 and PCSrc=0;
  - count=0 and top=0;
  - no push or pop occurs; stack contents need not be cleared.

## Timing
- Latency is 1 cycle. A request sampled at edge N drives all outputs after edge N; they are valid while out_valid=1 in cycle N+1.
- The core accepts one request per cycle with no backpressure, and sustains back-to-back requests.
- Back-to-back bl then ret: the ret in cycle N+1 sees the push from cycle N, so the RAS updates at the same edge as the outputs.
- Reset asserted: out_valid=0, PCSrc=0, exNPC=0, ra=0, both pulses 0, count=0, top=0.
  - Reset takes effect immediately, including mid-sequence.
  - The first request is accepted at the first rising edge after deassertion.

## Structure
- Package kgp_branch_pkg holds:
  - OPC_BRANCH=3'b011;
  - the fcode localparams FC_B through FC_RET;
  - a helper function for the condition evaluation.
- Sub-module branch_ras:
  - ports: clk, rst_n, clear, push, pop, push_data, pop_data, empty, overflow.
  - parameters: RAS_DEPTH and PC_W.
- The top level holds the decode, condition logic and output registers.

## Test plan
- Conditional branches: opcode 011, PC=120, label=150.
  - fcode 0111 with s=1 → next cycle PCSrc=1, exNPC=150.
  - fcode 0110 with v=1 → PCSrc=0, exNPC=121.
- Call then return:
  - bl at PC=120, label=300 → exNPC=300, ra=121.
  - ret next cycle → exNPC=121, PCSrc=1, no pulses.
- Overflow, RAS_DEPTH=8:
  - 9 bl requests from PC=0..8 → ras_overflow pulses on the 9th only.
  - Then 8 rets → exNPC = 9,8,...,2.
  - A 9th ret → ras_underflow=1, exNPC=rs_val[9:0].
- Edge cases:
  - PC=1023, fcode 0001 with z=0 → exNPC=0.
  - Label 25'h1FFFF96 with fcode 0000 → exNPC=10'h396.
  - Opcode 000 → PCSrc=0, ra=0.
- flush:
  - flush with a bl on the same cycle → out_valid=0 next cycle, RAS not pushed.
  - A following ret → ras_underflow.
- Reset:
  - rst_n low mid-stream after 3 pushes → all outputs 0 immediately.
  - After release, ret → ras_underflow=1.

Source files
------------

// File: rtl/kgp_branch_pkg.sv
// Shared constants for the KGP-RISC branch resolution stage: opcode class,
// branch function codes and the flag-based condition evaluation.
package kgp_branch_pkg;

    localparam logic [2:0] OPC_BRANCH = 3'b011;

    localparam logic [3:0] FC_B    = 4'b0000;
    localparam logic [3:0] FC_BZ   = 4'b0001;
    localparam logic [3:0] FC_BNZ  = 4'b0010;
    localparam logic [3:0] FC_BCY  = 4'b0011;
    localparam logic [3:0] FC_BNCY = 4'b0100;
    localparam logic [3:0] FC_BV   = 4'b0101;
    localparam logic [3:0] FC_BNV  = 4'b0110;
    localparam logic [3:0] FC_BLTZ = 4'b0111;
    localparam logic [3:0] FC_BL   = 4'b1000;
    localparam logic [3:0] FC_BR   = 4'b1001;
    localparam logic [3:0] FC_RET  = 4'b1010;

    // Only the flag-conditional codes are decided here; call/jump/return and
    // reserved codes report not-taken and are handled by the caller.
    function automatic logic cond_taken(input logic [3:0] fc,
                                        input logic c, input logic z,
                                        input logic v, input logic s);
        logic taken;
        taken = 1'b0;
        case (fc)
            FC_B:    taken = 1'b1;
            FC_BZ:   taken = z;
            FC_BNZ:  taken = !z;
            FC_BCY:  taken = c;
            FC_BNCY: taken = !c;
            FC_BV:   taken = v;
            FC_BNV:  taken = !v;
            FC_BLTZ: taken = s;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_resolve_ras_if.sv
// Request/response bundle between the execute path and the branch resolver.
interface branch_resolve_ras_if #(
    parameter int PC_W    = 10,
    parameter int LABEL_W = 25,
    parameter int XLEN    = 32
);
    logic               flush;
    logic               in_valid;
    logic [2:0]         opcode;
    logic [3:0]         fcode;
    logic [LABEL_W-1:0] label;
    logic               carryFlag;
    logic               zFlag;
    logic               overflowFlag;
    logic               signFlag;
    logic [PC_W-1:0]    PC;
    logic [XLEN-1:0]    rs_val;
    logic               out_valid;
    logic [PC_W-1:0]    exNPC;
    logic               PCSrc;
    logic [XLEN-1:0]    ra;
    logic               ras_overflow;
    logic               ras_underflow;

    modport master (
        output flush, in_valid, opcode, fcode, label,
               carryFlag, zFlag, overflowFlag, signFlag, PC, rs_val,
        input  out_valid, exNPC, PCSrc, ra, ras_overflow, ras_underflow
    );

    modport slave (
        input  flush, in_valid, opcode, fcode, label,
               carryFlag, zFlag, overflowFlag, signFlag, PC, rs_val,
        output out_valid, exNPC, PCSrc, ra, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/branch_ras.sv
// Circular return-address stack: push when full overwrites the oldest entry,
// pop reads entry[top] combinationally so the caller can register it.
module branch_ras #(
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            empty,
    output logic            overflow
);
    localparam int AW = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] r_mem [RAS_DEPTH];
    logic [AW-1:0]   r_top;
    logic [AW:0]     r_count;
    logic [AW-1:0]   w_top_inc;
    logic            w_full;

    assign w_top_inc = r_top + 1'b1;
    assign w_full    = (r_count == (AW+1)'(RAS_DEPTH));
    assign empty     = (r_count == '0);
    assign overflow  = push && w_full && !clear;
    assign pop_data  = r_mem[r_top];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_top <= w_top_inc;
            if (!w_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && !empty) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    // Storage is deliberately not reset; count/top alone define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[w_top_inc] <= push_data;
        end
    end
endmodule

// File: rtl/branch_resolve_ras.sv
// Branch resolution stage: decodes branch class, evaluates conditions, drives
// call/return through the RAS and registers all results with 1-cycle latency.
module branch_resolve_ras
    import kgp_branch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LABEL_W   = 25,
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_resolve_ras_if.slave bus
);
    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_npc;
    logic [PC_W-1:0] w_pop_data;
    logic [XLEN-1:0] w_ra;
    logic            w_src;
    logic            w_push;
    logic            w_pop;
    logic            w_underflow;
    logic            w_empty;
    logic            w_ras_overflow;
    logic            w_is_branch;
    logic            w_unused_bits;

    logic            r_out_valid;
    logic [PC_W-1:0] r_exnpc;
    logic            r_pcsrc;
    logic [XLEN-1:0] r_ra;
    logic            r_ovf;
    logic            r_unf;

    assign w_seq         = bus.PC + 1'b1;
    assign w_is_branch   = bus.in_valid && !bus.flush && (bus.opcode == OPC_BRANCH);
    assign w_unused_bits = ^{bus.label[LABEL_W-1:PC_W], bus.rs_val[XLEN-1:PC_W]};

    always_comb begin
        w_npc       = w_seq;
        w_src       = 1'b0;
        w_ra        = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (w_is_branch) begin
            case (bus.fcode)
                FC_BL: begin
                    w_src  = 1'b1;
                    w_npc  = bus.label[PC_W-1:0];
                    w_ra   = {{(XLEN-PC_W){1'b0}}, w_seq};
                    w_push = 1'b1;
                end
                FC_BR: begin
                    w_src = 1'b1;
                    w_npc = bus.rs_val[PC_W-1:0];
                end
                FC_RET: begin
                    w_src = 1'b1;
                    if (w_empty) begin
                        w_npc       = bus.rs_val[PC_W-1:0];
                        w_underflow = 1'b1;
                    end else begin
                        w_npc = w_pop_data;
                        w_pop = 1'b1;
                    end
                end
                default: begin
                    if (cond_taken(bus.fcode, bus.carryFlag, bus.zFlag,
                                   bus.overflowFlag, bus.signFlag)) begin
                        w_src = 1'b1;
                        w_npc = bus.label[PC_W-1:0];
                    end
                end
            endcase
        end
    end

    branch_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_seq),
        .pop_data  (w_pop_data),
        .empty     (w_empty),
        .overflow  (w_ras_overflow)
    );

    // Idle cycles hold exNPC/ra/PCSrc; only valid and the pulses drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_exnpc     <= '0;
            r_pcsrc     <= 1'b0;
            r_ra        <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (bus.in_valid) begin
            r_out_valid <= 1'b1;
            r_exnpc     <= w_npc;
            r_pcsrc     <= w_src;
            r_ra        <= w_ra;
            r_ovf       <= w_ras_overflow;
            r_unf       <= w_underflow;
        end else begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.exNPC         = r_exnpc;
    assign bus.PCSrc         = r_pcsrc;
    assign bus.ra            = r_ra;
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_branch_resolve_ras.sv
// Bench for branch_resolve_ras: directed scenarios plus randomized traffic
// checked against a queue-based return-stack model.
module tb_branch_resolve_ras;
    localparam int PC_W    = 10;
    localparam int LABEL_W = 25;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam logic [2:0] BR = 3'b011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_ras_if #(.PC_W(PC_W), .LABEL_W(LABEL_W), .XLEN(XLEN)) bif ();

    branch_resolve_ras #(
        .PC_W(PC_W), .LABEL_W(LABEL_W), .XLEN(XLEN), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: outputs as last produced, stack as a bounded queue
    logic [PC_W-1:0] m_stack[$];
    logic            m_valid, m_src, m_ovf, m_unf;
    logic [PC_W-1:0] m_npc;
    logic [XLEN-1:0] m_ra;

    task automatic model_reset();
        m_stack.delete();
        m_valid = 0; m_src = 0; m_ovf = 0; m_unf = 0; m_npc = '0; m_ra = '0;
    endtask

    task automatic model_step(input logic fl, input logic iv, input logic [2:0] op,
                              input logic [3:0] fc, input logic [LABEL_W-1:0] lb,
                              input logic [3:0] czvs, input logic [PC_W-1:0] pc,
                              input logic [XLEN-1:0] rs);
        int unsigned seq;
        bit taken;
        m_ovf = 0; m_unf = 0;
        if (fl) begin
            m_valid = 0; m_src = 0; m_stack.delete();
            return;
        end
        if (!iv) begin
            m_valid = 0;
            return;
        end
        seq = (int'(pc) + 1) % (1 << PC_W);
        m_valid = 1; m_src = 0; m_ra = '0; m_npc = PC_W'(seq);
        if (op != BR) return;
        taken = 0;
        case (int'(fc))
            0: taken = 1;
            1: taken = czvs[2];
            2: taken = !czvs[2];
            3: taken = czvs[3];
            4: taken = !czvs[3];
            5: taken = czvs[1];
            6: taken = !czvs[1];
            7: taken = czvs[0];
            8: begin
                m_src = 1; m_npc = lb[PC_W-1:0]; m_ra = XLEN'(seq);
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
                m_stack.push_back(PC_W'(seq));
            end
            9: begin m_src = 1; m_npc = rs[PC_W-1:0]; end
            10: begin
                m_src = 1;
                if (m_stack.size() > 0) m_npc = m_stack.pop_back();
                else begin m_npc = rs[PC_W-1:0]; m_unf = 1; end
            end
            default: taken = 0;
        endcase
        if (taken) begin m_src = 1; m_npc = lb[PC_W-1:0]; end
    endtask

    // One request: drive at negedge, let the edge sample it, settle, report
    task automatic send(input logic fl, input logic iv, input logic [2:0] op,
                        input logic [3:0] fc, input logic [LABEL_W-1:0] lb,
                        input logic [3:0] czvs, input logic [PC_W-1:0] pc,
                        input logic [XLEN-1:0] rs);
        @(negedge clk);
        bif.flush = fl; bif.in_valid = iv; bif.opcode = op; bif.fcode = fc;
        bif.label = lb; {bif.carryFlag, bif.zFlag, bif.overflowFlag, bif.signFlag} = czvs;
        bif.PC = pc; bif.rs_val = rs;
        @(posedge clk);
        model_step(fl, iv, op, fc, lb, czvs, pc, rs);
        #1;
        $display("[TB] t=%0t fl=%0b iv=%0b op=%0d fc=%0d pc=%0d -> v=%0b src=%0b npc=%0d ra=%0d ovf=%0b unf=%0b",
                 $time, fl, iv, op, fc, pc, bif.out_valid, bif.PCSrc, bif.exNPC, bif.ra,
                 bif.ras_overflow, bif.ras_underflow);
    endtask

    task automatic idle();
        send(0, 0, 3'd0, 4'd0, '0, 4'd0, '0, '0);
    endtask

    task automatic test_reset();
        bif.flush = 0; bif.in_valid = 0; bif.opcode = 0; bif.fcode = 0; bif.label = '0;
        bif.carryFlag = 0; bif.zFlag = 0; bif.overflowFlag = 0; bif.signFlag = 0;
        bif.PC = '0; bif.rs_val = '0;
        model_reset();
        #12;
        tests_run++; if (bif.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%0b exp=0", bif.out_valid); end
        tests_run++; if (bif.PCSrc !== 1'b0) begin tests_failed++; $display("FAIL reset_PCSrc got=%0b exp=0", bif.PCSrc); end
        tests_run++; if (bif.exNPC !== '0) begin tests_failed++; $display("FAIL reset_exNPC got=%0d exp=0", bif.exNPC); end
        tests_run++; if (bif.ra !== '0) begin tests_failed++; $display("FAIL reset_ra got=%0d exp=0", bif.ra); end
        tests_run++; if (bif.ras_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%0b exp=0", bif.ras_overflow); end
        tests_run++; if (bif.ras_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_unf got=%0b exp=0", bif.ras_underflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_cond();
        send(0, 1, BR, 4'b0111, 25'd150, 4'b0001, 10'd120, 32'd0);
        tests_run++; if (bif.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bltz_valid got=%0b exp=1", bif.out_valid); end
        tests_run++; if (bif.PCSrc !== 1'b1) begin tests_failed++; $display("FAIL bltz_PCSrc got=%0b exp=1", bif.PCSrc); end
        tests_run++; if (bif.exNPC !== 10'd150) begin tests_failed++; $display("FAIL bltz_exNPC got=%0d exp=150", bif.exNPC); end
        send(0, 1, BR, 4'b0110, 25'd150, 4'b0010, 10'd120, 32'd0);
        tests_run++; if (bif.PCSrc !== 1'b0) begin tests_failed++; $display("FAIL bnv_PCSrc got=%0b exp=0", bif.PCSrc); end
        tests_run++; if (bif.exNPC !== 10'd121) begin tests_failed++; $display("FAIL bnv_exNPC got=%0d exp=121", bif.exNPC); end
    endtask

    task automatic test_call_ret();
        send(0, 1, BR, 4'b1000, 25'd300, 4'b0000, 10'd120, 32'd0);
        tests_run++; if (bif.exNPC !== 10'd300) begin tests_failed++; $display("FAIL bl_exNPC got=%0d exp=300", bif.exNPC); end
        tests_run++; if (bif.ra !== 32'd121) begin tests_failed++; $display("FAIL bl_ra got=%0d exp=121", bif.ra); end
        send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd300, 32'd77);
        tests_run++; if (bif.exNPC !== 10'd121) begin tests_failed++; $display("FAIL ret_exNPC got=%0d exp=121", bif.exNPC); end
        tests_run++; if (bif.PCSrc !== 1'b1) begin tests_failed++; $display("FAIL ret_PCSrc got=%0b exp=1", bif.PCSrc); end
        tests_run++; if ({bif.ras_overflow, bif.ras_underflow} !== 2'b00) begin tests_failed++; $display("FAIL ret_pulses got=%b exp=00", {bif.ras_overflow, bif.ras_underflow}); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            send(0, 1, BR, 4'b1000, 25'(500 + i), 4'b0000, 10'(i), 32'd0);
            tests_run++;
            if (bif.ras_overflow !== (i == 8)) begin tests_failed++; $display("FAIL ovf_push%0d got=%0b exp=%0b", i, bif.ras_overflow, (i == 8)); end
        end
        for (int k = 0; k < 8; k++) begin
            send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd900, $urandom);
            tests_run++;
            if (bif.exNPC !== 10'(9 - k) || bif.ras_underflow !== 1'b0) begin
                tests_failed++; $display("FAIL ovf_pop%0d got=%0d/%0b exp=%0d/0", k, bif.exNPC, bif.ras_underflow, 9 - k);
            end
        end
        send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd900, 32'hABCD_E123);
        tests_run++; if (bif.ras_underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_pulse got=%0b exp=1", bif.ras_underflow); end
        tests_run++; if (bif.exNPC !== 10'h123) begin tests_failed++; $display("FAIL unf_exNPC got=%0h exp=123", bif.exNPC); end
        idle();
        tests_run++; if (bif.ras_underflow !== 1'b0 || bif.out_valid !== 1'b0 || bif.exNPC !== 10'h123) begin
            tests_failed++; $display("FAIL idle_hold got=%0b/%0b/%0h exp=0/0/123", bif.ras_underflow, bif.out_valid, bif.exNPC);
        end
    endtask

    task automatic test_edges();
        send(0, 1, BR, 4'b0001, 25'd5, 4'b0000, 10'd1023, 32'd0);
        tests_run++; if (bif.exNPC !== 10'd0 || bif.PCSrc !== 1'b0) begin tests_failed++; $display("FAIL pc_wrap got=%0d/%0b exp=0/0", bif.exNPC, bif.PCSrc); end
        send(0, 1, BR, 4'b0000, 25'h1FFFF96, 4'b0000, 10'd40, 32'd0);
        tests_run++; if (bif.exNPC !== 10'h396 || bif.PCSrc !== 1'b1) begin tests_failed++; $display("FAIL label_trunc got=%0h/%0b exp=396/1", bif.exNPC, bif.PCSrc); end
        send(0, 1, 3'b000, 4'b1000, 25'd77, 4'b1111, 10'd60, 32'd0);
        tests_run++; if (bif.PCSrc !== 1'b0 || bif.ra !== '0 || bif.exNPC !== 10'd61) begin tests_failed++; $display("FAIL nonbranch got=%0b/%0d/%0d exp=0/0/61", bif.PCSrc, bif.ra, bif.exNPC); end
        send(0, 1, BR, 4'b1101, 25'd88, 4'b1111, 10'd70, 32'd0);
        tests_run++; if (bif.PCSrc !== 1'b0 || bif.exNPC !== 10'd71) begin tests_failed++; $display("FAIL reserved got=%0b/%0d exp=0/71", bif.PCSrc, bif.exNPC); end
        send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd80, 32'd555);
        tests_run++; if (bif.ras_underflow !== 1'b1) begin tests_failed++; $display("FAIL nonbranch_no_push got=%0b exp=1", bif.ras_underflow); end
    endtask

    task automatic test_flush();
        send(0, 1, BR, 4'b1000, 25'd200, 4'b0000, 10'd5, 32'd0);
        send(1, 1, BR, 4'b1000, 25'd210, 4'b0000, 10'd6, 32'd0);
        tests_run++; if (bif.out_valid !== 1'b0 || bif.PCSrc !== 1'b0) begin tests_failed++; $display("FAIL flush_out got=%0b/%0b exp=0/0", bif.out_valid, bif.PCSrc); end
        send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd7, 32'd333);
        tests_run++; if (bif.ras_underflow !== 1'b1 || bif.exNPC !== 10'd333) begin tests_failed++; $display("FAIL flush_empty got=%0b/%0d exp=1/333", bif.ras_underflow, bif.exNPC); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(0, 1, BR, 4'b1000, 25'(400 + i), 4'b0000, 10'(20 + i), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++; if ({bif.out_valid, bif.PCSrc, bif.ras_overflow, bif.ras_underflow} !== 4'b0000) begin
            tests_failed++; $display("FAIL midreset_flags got=%b exp=0000", {bif.out_valid, bif.PCSrc, bif.ras_overflow, bif.ras_underflow});
        end
        tests_run++; if (bif.exNPC !== '0 || bif.ra !== '0) begin tests_failed++; $display("FAIL midreset_data got=%0d/%0d exp=0/0", bif.exNPC, bif.ra); end
        bif.in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        send(0, 1, BR, 4'b1010, 25'd0, 4'b0000, 10'd30, 32'd444);
        tests_run++; if (bif.ras_underflow !== 1'b1 || bif.exNPC !== 10'd444) begin tests_failed++; $display("FAIL midreset_ret got=%0b/%0d exp=1/444", bif.ras_underflow, bif.exNPC); end
    endtask

    task automatic test_random();
        logic fl, iv;
        logic [2:0] op;
        logic [3:0] fc;
        for (int n = 0; n < 400; n++) begin
            fl = ($urandom_range(0, 15) == 0);
            iv = ($urandom_range(0, 7) != 0);
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : BR;
            case ($urandom_range(0, 3))
                0: fc = 4'b1000;
                1: fc = 4'b1010;
                default: fc = 4'($urandom);
            endcase
            send(fl, iv, op, fc, 25'($urandom), 4'($urandom), 10'($urandom), $urandom);
            tests_run++; if (bif.out_valid !== m_valid) begin tests_failed++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", n, bif.out_valid, m_valid); end
            tests_run++; if (bif.PCSrc !== m_src) begin tests_failed++; $display("FAIL rnd%0d_PCSrc got=%0b exp=%0b", n, bif.PCSrc, m_src); end
            tests_run++; if (bif.exNPC !== m_npc) begin tests_failed++; $display("FAIL rnd%0d_exNPC got=%0d exp=%0d", n, bif.exNPC, m_npc); end
            tests_run++; if (bif.ra !== m_ra) begin tests_failed++; $display("FAIL rnd%0d_ra got=%0d exp=%0d", n, bif.ra, m_ra); end
            tests_run++; if (bif.ras_overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd%0d_ovf got=%0b exp=%0b", n, bif.ras_overflow, m_ovf); end
            tests_run++; if (bif.ras_underflow !== m_unf) begin tests_failed++; $display("FAIL rnd%0d_unf got=%0b exp=%0b", n, bif.ras_underflow, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_cond();
        test_call_ret();
        test_overflow();
        test_edges();
        test_flush();
        test_reset_mid();
        test_random();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
